spi_slave_v3: RTL and testbench

Parametrised, single-clock SPI slave that bridges an external SPI master to two on-chip valid/ready byte streams through internal FIFOs. SCK, MOSI and SSEL are oversampled in the system clock domain, so no logic is clocked by SCK and no clock-domain converter is needed. Adds configurable SPI mode, frame width, FIFO depth, underflow fill word, sticky error flags and FIFO flush on the reset opcode.

---
 rtl/spi_slave_v3.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_slave_v3.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_v3.sv
// spi_slave_v3: SPI slave oversampled in the system clock domain. It bridges
// an SPI master to two valid/ready byte streams through internal FIFOs.
//   clk, reset (async, active low)       system clock / reset
//   SCK, MOSI, SSEL in; MISO out         SPI pins (SSEL active low)
//   read_data/read_vld/read_rdy          RX FIFO head (host -> fabric), FWFT
//   write_data/write_vld/write_rdy       TX FIFO push (fabric -> host)
//   spi_reset                            1-clk pulse on RESET opcode
//   rx_overflow, tx_underflow            sticky error flags

// Synchronous FIFO with flush. A push on full is accepted only when a pop
// frees a slot in the same clk, so simultaneous push+pop keeps the count.
//   clk_i, rst_ni    clock / async active-low reset
//   flush_i          empties the FIFO (wins over push/pop)
//   push_i, wdata_i  write side;  pop_i, rdata_o  read side (FWFT)
//   count_o, empty_o, full_o  occupancy
module spi_slave_v3_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module spi_slave_v3 #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 16,
  parameter int               CPOL        = 0,
  parameter int               CPHA        = 0,
  parameter logic [WIDTH-1:0] FILL        = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             SSEL,
  output logic [WIDTH-1:0] read_data,
  output logic             read_vld,
  input  logic             read_rdy,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_vld,
  output logic             write_rdy,
  output logic             spi_reset,
  output logic             rx_overflow,
  output logic             tx_underflow
);
  localparam int   BW     = $clog2(WIDTH);
  localparam int   CW     = $clog2(DEPTH+1);
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic [WIDTH-1:0] OP_STATUS = WIDTH'(8'h81);
  localparam logic [WIDTH-1:0] OP_READ   = WIDTH'(8'h82);
  localparam logic [WIDTH-1:0] OP_WRITE  = WIDTH'(8'h04);
  localparam logic [WIDTH-1:0] OP_WR_RD  = WIDTH'(8'h86);
  localparam logic [WIDTH-1:0] OP_RESET  = WIDTH'(8'h08);

  typedef enum logic [2:0] {S_IDLE, S_STATUS, S_READ, S_WRITE, S_WR_RD, S_DISCARD} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ssel_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, mosi_s, active, rise, fall, lead, trail;
  logic                   sample_evt, shift_evt, frame_done;
  logic [WIDTH-1:0]       rx_word, tx_load, tx_sr_q, tx_rdata;
  logic [WIDTH-2:0]       rx_sr_q;
  logic [BW-1:0]          bitcnt_q;
  logic [1:0]             stat_cnt_q;
  logic                   load_q, tx_pop, uf_set;
  logic                   rx_push, rx_drop, rst_op, stat_clr;
  logic                   rx_empty, rx_full, tx_empty, tx_full;
  logic [CW-1:0]          rx_count, tx_count;
  logic                   spi_reset_q, rx_of_q, tx_uf_q, rx_of_d, tx_uf_d;
  state_e                 state_q;

  // Pin synchronisers; reset to the idle pin levels so no false edge appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL_B}};
      mosi_sync_q <= '0;
      ssel_sync_q <= '1;
      sck_prev_q  <= CPOL_B;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign active     = ~ssel_sync_q[SYNC_STAGES-1];
  assign rise       = sck_s & ~sck_prev_q;
  assign fall       = ~sck_s & sck_prev_q;
  assign lead       = CPOL_B ? fall : rise;
  assign trail      = CPOL_B ? rise : fall;
  assign sample_evt = active & ((CPHA == 0) ? lead : trail);
  assign shift_evt  = active & ((CPHA == 0) ? trail : lead);
  assign rx_word    = {rx_sr_q, mosi_s};
  assign frame_done = sample_evt & (bitcnt_q == BW'(WIDTH-1));

  assign rx_push  = frame_done & ((state_q == S_WRITE) | (state_q == S_WR_RD));
  assign rx_drop  = rx_push & rx_full & ~(read_rdy & ~rx_empty);
  assign rst_op   = frame_done & (state_q == S_IDLE) & (rx_word == OP_RESET);
  assign stat_clr = frame_done & (state_q == S_STATUS) & (stat_cnt_q == 2'd2);

  // Next transmit word, latched one clk after a frame completes so the
  // state and status index already reflect that frame.
  always_comb begin
    tx_load = '0;
    tx_pop  = 1'b0;
    uf_set  = 1'b0;
    if (load_q && active) begin
      case (state_q)
        S_STATUS: begin
          case (stat_cnt_q)
            2'd0:    tx_load = WIDTH'(DEPTH) - WIDTH'(rx_count);
            2'd1:    tx_load = WIDTH'(tx_count);
            2'd2:    tx_load = {{(WIDTH-2){1'b0}}, tx_uf_q, rx_of_q};
            default: tx_load = '0;
          endcase
        end
        S_READ, S_WR_RD: begin
          if (!tx_empty) begin
            tx_load = tx_rdata;
            tx_pop  = 1'b1;
          end else begin
            tx_load = FILL;
            uf_set  = 1'b1;
          end
        end
        default: tx_load = '0;
      endcase
    end
  end

  // Shifting is suppressed while bitcnt is 0: for CPHA=0 that skips the
  // trailing edge after the last sample (which would clobber a fresh load),
  // for CPHA=1 the first leading edge just exposes the already-loaded MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      load_q     <= 1'b0;
      stat_cnt_q <= '0;
    end else if (!active) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      tx_sr_q  <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= frame_done;
      if (sample_evt) begin
        rx_sr_q  <= rx_word[WIDTH-2:0];
        bitcnt_q <= frame_done ? '0 : bitcnt_q + BW'(1);
      end
      if (frame_done) begin
        case (state_q)
          S_IDLE: begin
            stat_cnt_q <= '0;
            case (rx_word)
              OP_STATUS: state_q <= S_STATUS;
              OP_READ:   state_q <= S_READ;
              OP_WRITE:  state_q <= S_WRITE;
              OP_WR_RD:  state_q <= S_WR_RD;
              default:   state_q <= S_DISCARD;
            endcase
          end
          S_STATUS: if (stat_cnt_q != 2'd3) stat_cnt_q <= stat_cnt_q + 2'd1;
          default: ;
        endcase
      end
      if (load_q)
        tx_sr_q <= tx_load;
      else if (shift_evt && bitcnt_q != '0)
        tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sticky flags: a set in the clearing clk wins over the clear.
  assign rx_of_d = rst_op ? 1'b0 : ((rx_of_q & ~stat_clr) | rx_drop);
  assign tx_uf_d = rst_op ? 1'b0 : ((tx_uf_q & ~stat_clr) | uf_set);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_reset_q <= 1'b0;
      rx_of_q     <= 1'b0;
      tx_uf_q     <= 1'b0;
    end else begin
      spi_reset_q <= rst_op;
      rx_of_q     <= rx_of_d;
      tx_uf_q     <= tx_uf_d;
    end
  end

  spi_slave_v3_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i(clk), .rst_ni(reset), .flush_i(rst_op),
    .push_i(rx_push), .wdata_i(rx_word), .pop_i(read_rdy), .rdata_o(read_data),
    .count_o(rx_count), .empty_o(rx_empty), .full_o(rx_full)
  );

  spi_slave_v3_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i(clk), .rst_ni(reset), .flush_i(rst_op),
    .push_i(write_vld), .wdata_i(write_data), .pop_i(tx_pop), .rdata_o(tx_rdata),
    .count_o(tx_count), .empty_o(tx_empty), .full_o(tx_full)
  );

  assign MISO         = active & tx_sr_q[WIDTH-1];
  assign read_vld     = ~rx_empty;
  assign write_rdy    = ~tx_full;
  assign spi_reset    = spi_reset_q;
  assign rx_overflow  = rx_of_q;
  assign tx_underflow = tx_uf_q;
endmodule

// File: tb/tb_spi_slave_v3.sv
// Bench for spi_slave_v3. dut0: mode 0, DEPTH 4, FILL 0x00.
// dut1: mode 3, DEPTH 16, FILL 0xE7. Expected MISO bytes and RX words go
// into queues when stimulus is driven and are compared when the DUT emits.
module tb_spi_slave_v3;
  localparam int HALF = 6;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck[2], mosi[2], miso[2], ssel[2];
  logic [7:0] rdata[2], wdata[2];
  logic       rvld[2], rrdy[2], wvld[2], wrdy[2], srst[2], rxof[2], txuf[2];
  int         checks = 0;
  int         errs   = 0;
  int         pulses0 = 0;
  int         pulses1 = 0;
  logic [7:0] rxq0[$], rxq1[$], mq[$];

  always #5 clk = ~clk;

  spi_slave_v3 #(.WIDTH(8), .DEPTH(4), .CPOL(0), .CPHA(0), .FILL(8'h00), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(rst_n), .SCK(sck[0]), .MOSI(mosi[0]), .MISO(miso[0]), .SSEL(ssel[0]),
    .read_data(rdata[0]), .read_vld(rvld[0]), .read_rdy(rrdy[0]),
    .write_data(wdata[0]), .write_vld(wvld[0]), .write_rdy(wrdy[0]),
    .spi_reset(srst[0]), .rx_overflow(rxof[0]), .tx_underflow(txuf[0])
  );

  spi_slave_v3 #(.WIDTH(8), .DEPTH(16), .CPOL(1), .CPHA(1), .FILL(8'hE7), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(rst_n), .SCK(sck[1]), .MOSI(mosi[1]), .MISO(miso[1]), .SSEL(ssel[1]),
    .read_data(rdata[1]), .read_vld(rvld[1]), .read_rdy(rrdy[1]),
    .write_data(wdata[1]), .write_vld(wvld[1]), .write_rdy(wrdy[1]),
    .spi_reset(srst[1]), .rx_overflow(rxof[1]), .tx_underflow(txuf[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RX scoreboard and spi_reset pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvld[0] && rrdy[0]) begin
        if (rxq0.size() == 0) chk("rx0_unexpected", {24'h0, rdata[0]}, 32'hFFFF_FFFF);
        else                  chk("rx0_data", {24'h0, rdata[0]}, {24'h0, rxq0.pop_front()});
      end
      if (rvld[1] && rrdy[1]) begin
        if (rxq1.size() == 0) chk("rx1_unexpected", {24'h0, rdata[1]}, 32'hFFFF_FFFF);
        else                  chk("rx1_data", {24'h0, rdata[1]}, {24'h0, rxq1.pop_front()});
      end
      if (srst[0]) pulses0++;
      if (srst[1]) pulses1++;
    end
  end

  task automatic set_rdy(input int d, input logic v);
    @(posedge clk); #1;
    rrdy[d] = v;
  endtask

  task automatic push_tx(input int d, input logic [7:0] v);
    @(negedge clk);
    wdata[d] = v;
    wvld[d]  = 1'b1;
    @(negedge clk);
    wvld[d]  = 1'b0;
  endtask

  task automatic sel(input int d);
    @(negedge clk);
    ssel[d] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic desel(input int d);
    repeat (HALF) @(negedge clk);
    ssel[d] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Master side of one frame (d=0 mode 0, d=1 mode 3); MISO sampled just
  // before the sampling edge. Full frames compare against the MISO queue.
  task automatic frame(input int d, input logic [7:0] mo, input int nbits);
    logic [7:0] got;
    got = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (d == 1) sck[d] = 1'b0;
      mosi[d] = mo[i];
      repeat (HALF) @(negedge clk);
      got[i] = miso[d];
      sck[d] = 1'b1;
      repeat (HALF) @(negedge clk);
      if (d == 0) sck[d] = 1'b0;
    end
    if (nbits == 8) begin
      if (mq.size() == 0) chk("miso_unexpected", {24'h0, got}, 32'hFFFF_FFFF);
      else chk($sformatf("miso%0d", d), {24'h0, got}, {24'h0, mq.pop_front()});
    end
  endtask

  task automatic send(input int d, input logic [7:0] mo, input logic [7:0] ex);
    mq.push_back(ex);
    frame(d, mo, 8);
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 300; n++) begin
      if ((d == 0 ? rxq0.size() : rxq1.size()) == 0) break;
      @(negedge clk);
    end
    chk($sformatf("rx%0d_drain", d), d == 0 ? rxq0.size() : rxq1.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ssel[d] = 1'b1; mosi[d] = 1'b0; rrdy[d] = 1'b0; wvld[d] = 1'b0; wdata[d] = '0;
    end
    sck[0] = 1'b0;
    sck[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_miso%0d", d), miso[d], 0);
      chk($sformatf("rst_rvld%0d", d), rvld[d], 0);
      chk($sformatf("rst_wrdy%0d", d), wrdy[d], 1);
      chk($sformatf("rst_srst%0d", d), srst[d], 0);
      chk($sformatf("rst_rxof%0d", d), rxof[d], 0);
      chk($sformatf("rst_txuf%0d", d), txuf[d], 0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0 WRITE of two bytes.
    set_rdy(0, 1'b1);
    sel(0);
    send(0, 8'h04, 8'h00);
    rxq0.push_back(8'hA5); send(0, 8'hA5, 8'h00);
    rxq0.push_back(8'h3C); send(0, 8'h3C, 8'h00);
    desel(0);
    drain(0);
    chk("write_rxof", rxof[0], 0);

    // Mode 3 READ, fourth frame underflows to FILL.
    push_tx(1, 8'h11);
    push_tx(1, 8'h22);
    sel(1);
    send(1, 8'h82, 8'h00);
    send(1, 8'h00, 8'h11);
    send(1, 8'h00, 8'h22);
    send(1, 8'h00, 8'hE7);
    desel(1);
    chk("read_txuf", txuf[1], 1);

    // RX overflow on DEPTH 4, then READ_STATUS clears it.
    set_rdy(0, 1'b0);
    sel(0);
    send(0, 8'h04, 8'h00);
    for (int v = 1; v <= 6; v++) begin
      if (v <= 4) rxq0.push_back(8'(v));
      send(0, 8'(v), 8'h00);
    end
    desel(0);
    chk("ovf_rxof", rxof[0], 1);
    chk("ovf_rvld", rvld[0], 1);
    sel(0);
    send(0, 8'h81, 8'h00);
    send(0, 8'h00, 8'h00);
    send(0, 8'h00, 8'h00);
    send(0, 8'h00, 8'h01);
    send(0, 8'h00, 8'h00);
    desel(0);
    chk("stat_rxof_clr", rxof[0], 0);
    set_rdy(0, 1'b1);
    drain(0);

    // WRITE_READ in mode 3.
    set_rdy(1, 1'b1);
    push_tx(1, 8'h55);
    sel(1);
    send(1, 8'h86, 8'h00);
    rxq1.push_back(8'h99); send(1, 8'h99, 8'h55);
    desel(1);
    drain(1);

    // SSEL rise after 5 bits of a data frame, then a clean transaction.
    sel(0);
    send(0, 8'h04, 8'h00);
    frame(0, 8'hF0, 5);
    desel(0);
    repeat (20) @(negedge clk);
    chk("partial_rvld", rvld[0], 0);
    sel(0);
    send(0, 8'h04, 8'h00);
    rxq0.push_back(8'h77); send(0, 8'h77, 8'h00);
    desel(0);
    drain(0);

    // RESET opcode with both FIFOs holding data.
    push_tx(1, 8'h33);
    set_rdy(1, 1'b0);
    sel(1);
    send(1, 8'h04, 8'h00);
    send(1, 8'h42, 8'h00);
    desel(1);
    chk("pre_rst_rvld", rvld[1], 1);
    b1 = pulses1;
    sel(1);
    send(1, 8'h08, 8'h00);
    send(1, 8'h12, 8'h00);
    desel(1);
    chk("rst_pulse_len", pulses1 - b1, 1);
    chk("rst_op_rvld", rvld[1], 0);
    chk("rst_op_wrdy", wrdy[1], 1);
    chk("rst_op_txuf", txuf[1], 0);
    chk("rst_op_rxof", rxof[1], 0);
    set_rdy(1, 1'b1);
    sel(1);
    send(1, 8'h82, 8'h00);
    send(1, 8'h00, 8'hE7);
    desel(1);

    // Unknown opcode: all zeros, TX FIFO untouched.
    b0 = pulses0;
    push_tx(0, 8'h5A);
    sel(0);
    send(0, 8'hFF, 8'h00);
    send(0, 8'hAB, 8'h00);
    send(0, 8'hCD, 8'h00);
    desel(0);
    chk("unk_rvld", rvld[0], 0);
    chk("unk_no_rst", pulses0 - b0, 0);
    sel(0);
    send(0, 8'h82, 8'h00);
    send(0, 8'h00, 8'h5A);
    desel(0);

    chk("miso_queue_empty", mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
